// File: rtl/riscv_regfile_sb.sv
// RISC-V integer register file with issue scoreboard: 31 GPRs, one write port,
// two registered operand reads per issued instruction, RAW/WAW stall, flush.
module riscv_regfile_sb #(
  parameter int unsigned BYPASS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_vld,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_en,
  output logic        issue_rdy,
  output logic        dispatch_vld,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        flush,
  output logic [31:0] busy
);

  localparam bit Forward = (BYPASS != 0);

  logic [31:0] regs_q [32];
  logic [31:0] busy_q, busy_d;
  logic        dispVld_q;
  logic [31:0] rs1Data_q, rs1Data_d;
  logic [31:0] rs2Data_q, rs2Data_d;

  logic wrHit, rs1Fwd, rs2Fwd, rs1Haz, rs2Haz, wawHaz, fire;

  always_comb begin
    wrHit  = wr_en && (wr_addr != 5'd0);
    rs1Fwd = Forward && wrHit && (wr_addr == issue_rs1);
    rs2Fwd = Forward && wrHit && (wr_addr == issue_rs2);
    rs1Haz = (issue_rs1 != 5'd0) && busy_q[issue_rs1] && !rs1Fwd;
    rs2Haz = (issue_rs2 != 5'd0) && busy_q[issue_rs2] && !rs2Fwd;
    // A same-cycle writeback retires the older writer, so WAW clears regardless of BYPASS.
    wawHaz = issue_rd_en && (issue_rd != 5'd0) && busy_q[issue_rd]
             && !(wrHit && (wr_addr == issue_rd));
    issue_rdy = !reset && !flush && !rs1Haz && !rs2Haz && !wawHaz;
    fire      = issue_vld && issue_rdy;
  end

  always_comb begin
    rs1Data_d = rs1Data_q;
    rs2Data_d = rs2Data_q;
    if (fire) begin
      if (issue_rs1 == 5'd0)  rs1Data_d = '0;
      else if (rs1Fwd)        rs1Data_d = wr_data;
      else                    rs1Data_d = regs_q[issue_rs1];
      if (issue_rs2 == 5'd0)  rs2Data_d = '0;
      else if (rs2Fwd)        rs2Data_d = wr_data;
      else                    rs2Data_d = regs_q[issue_rs2];
    end
  end

  // Writeback clear first, then issue set, so a colliding set wins.
  always_comb begin
    busy_d = busy_q;
    if (wrHit)
      busy_d[wr_addr] = 1'b0;
    if (fire && issue_rd_en && (issue_rd != 5'd0))
      busy_d[issue_rd] = 1'b1;
    if (flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      dispVld_q <= 1'b0;
      rs1Data_q <= '0;
      rs2Data_q <= '0;
    end else begin
      if (wrHit) regs_q[wr_addr] <= wr_data;
      busy_q    <= busy_d;
      dispVld_q <= fire;
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
    end
  end

  assign dispatch_vld = dispVld_q;
  assign rs1_data     = rs1Data_q;
  assign rs2_data     = rs2Data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Bench for riscv_regfile_sb: one forwarding and one non-forwarding instance
// share stimulus and are each checked every cycle against an architectural model.
module tb_riscv_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic        issueVld;
  logic [4:0]  issueRs1, issueRs2, issueRd;
  logic        issueRdEn;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        flush;

  logic [1:0]  issueRdy, dispVld;
  logic [31:0] rs1Out [2];
  logic [31:0] rs2Out [2];
  logic [31:0] busyOut [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  riscv_regfile_sb #(.BYPASS(0)) dut0 (
    .clock(clock), .reset(reset),
    .issue_vld(issueVld), .issue_rs1(issueRs1), .issue_rs2(issueRs2),
    .issue_rd(issueRd), .issue_rd_en(issueRdEn), .issue_rdy(issueRdy[0]),
    .dispatch_vld(dispVld[0]), .rs1_data(rs1Out[0]), .rs2_data(rs2Out[0]),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .flush(flush), .busy(busyOut[0])
  );

  riscv_regfile_sb #(.BYPASS(1)) dut1 (
    .clock(clock), .reset(reset),
    .issue_vld(issueVld), .issue_rs1(issueRs1), .issue_rs2(issueRs2),
    .issue_rd(issueRd), .issue_rd_en(issueRdEn), .issue_rdy(issueRdy[1]),
    .dispatch_vld(dispVld[1]), .rs1_data(rs1Out[1]), .rs2_data(rs2Out[1]),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .flush(flush), .busy(busyOut[1])
  );

  // Architectural state per instance (index 0 = no forwarding, 1 = forwarding).
  bit [31:0] mRegs [2][32];
  bit [31:0] mBusy [2];
  bit        mDisp [2];
  bit [31:0] mRs1 [2];
  bit [31:0] mRs2 [2];
  bit [31:0] nRegs [2][32];
  bit [31:0] nBusy [2];
  bit        nDisp [2];
  bit [31:0] nRs1 [2];
  bit [31:0] nRs2 [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rdEn, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    issueVld  = vld;
    issueRs1  = rs1;
    issueRs2  = rs2;
    issueRd   = rd;
    issueRdEn = rdEn;
    wrEn      = we;
    wrAddr    = wa;
    wrData    = wd;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkBoth(input string name, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] exp);
    checkOutput({name, "_nobyp"}, a0, exp);
    checkOutput({name, "_byp"}, a1, exp);
  endtask

  // Predict from the rules: reads see architectural state (or this cycle's write
  // when forwarding), hazards are busy sources/destination not retired this cycle.
  always @(negedge clock) begin
    for (int b = 0; b < 2; b++) begin
      bit wrOk, hz1, hz2, waw, expRdy, fire;
      wrOk   = !reset && wrEn && (wrAddr != 5'd0);
      hz1    = (issueRs1 != 0) && mBusy[b][issueRs1] && !(b == 1 && wrOk && wrAddr == issueRs1);
      hz2    = (issueRs2 != 0) && mBusy[b][issueRs2] && !(b == 1 && wrOk && wrAddr == issueRs2);
      waw    = issueRdEn && (issueRd != 0) && mBusy[b][issueRd] && !(wrOk && wrAddr == issueRd);
      expRdy = !reset && !flush && !hz1 && !hz2 && !waw;
      fire   = issueVld && expRdy;

      checkOutput($sformatf("issue_rdy[b%0d]", b), {31'd0, issueRdy[b]}, {31'd0, expRdy});
      checkOutput($sformatf("dispatch_vld[b%0d]", b), {31'd0, dispVld[b]}, {31'd0, mDisp[b]});
      checkOutput($sformatf("rs1_data[b%0d]", b), rs1Out[b], mRs1[b]);
      checkOutput($sformatf("rs2_data[b%0d]", b), rs2Out[b], mRs2[b]);
      checkOutput($sformatf("busy[b%0d]", b), busyOut[b], mBusy[b]);

      for (int r = 0; r < 32; r++) nRegs[b][r] = mRegs[b][r];
      if (wrOk) nRegs[b][wrAddr] = wrData;
      nRs1[b] = mRs1[b];
      nRs2[b] = mRs2[b];
      if (fire) begin
        nRs1[b] = (issueRs1 == 0) ? 32'd0 :
                  (b == 1 && wrOk && wrAddr == issueRs1) ? wrData : mRegs[b][issueRs1];
        nRs2[b] = (issueRs2 == 0) ? 32'd0 :
                  (b == 1 && wrOk && wrAddr == issueRs2) ? wrData : mRegs[b][issueRs2];
      end
      nBusy[b] = mBusy[b];
      if (wrOk) nBusy[b][wrAddr] = 1'b0;
      if (fire && issueRdEn && issueRd != 0) nBusy[b][issueRd] = 1'b1;
      if (flush) nBusy[b] = 32'd0;
      nDisp[b] = fire;
    end
  end

  always @(posedge clock or posedge reset) begin
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 32; r++) mRegs[b][r] = reset ? 32'd0 : nRegs[b][r];
      mBusy[b] = reset ? 32'd0 : nBusy[b];
      mDisp[b] = reset ? 1'b0  : nDisp[b];
      mRs1[b]  = reset ? 32'd0 : nRs1[b];
      mRs2[b]  = reset ? 32'd0 : nRs2[b];
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkBoth("rst_dispatch", {31'd0, dispVld[0]}, {31'd0, dispVld[1]}, 32'd0);
    checkBoth("rst_busy", busyOut[0], busyOut[1], 32'd0);
    checkBoth("rst_rs1", rs1Out[0], rs1Out[1], 32'd0);
    step();
    reset = 1'b0;

    // Basic read
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 32'h0000_1234, 0);
    step();
    applyStimulus(1, 5, 0, 6, 1, 0, 0, 0, 0);
    #1 checkBoth("basic_rdy", {31'd0, issueRdy[0]}, {31'd0, issueRdy[1]}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkBoth("basic_disp", {31'd0, dispVld[0]}, {31'd0, dispVld[1]}, 32'd1);
    checkBoth("basic_rs1", rs1Out[0], rs1Out[1], 32'h0000_1234);
    checkBoth("basic_rs2", rs2Out[0], rs2Out[1], 32'd0);
    checkBoth("basic_busy6", {31'd0, busyOut[0][6]}, {31'd0, busyOut[1][6]}, 32'd1);

    // RAW stall on x6
    applyStimulus(1, 6, 0, 8, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 checkBoth("raw_stall", {31'd0, issueRdy[0]}, {31'd0, issueRdy[1]}, 32'd0);
      step();
    end
    applyStimulus(1, 6, 0, 8, 1, 1, 6, 32'hDEAD_BEEF, 0);
    #1 checkOutput("raw_wb_rdy_byp", {31'd0, issueRdy[1]}, 32'd1);
    checkOutput("raw_wb_rdy_nobyp", {31'd0, issueRdy[0]}, 32'd0);
    step();
    applyStimulus(1, 6, 0, 8, 1, 0, 0, 0, 0);
    #1 checkOutput("raw_disp_byp", {31'd0, dispVld[1]}, 32'd1);
    checkOutput("raw_rs1_byp", rs1Out[1], 32'hDEAD_BEEF);
    checkOutput("raw_disp_nobyp", {31'd0, dispVld[0]}, 32'd0);
    checkOutput("raw_late_rdy_nobyp", {31'd0, issueRdy[0]}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_disp_nobyp_late", {31'd0, dispVld[0]}, 32'd1);
    checkOutput("raw_rs1_nobyp", rs1Out[0], 32'hDEAD_BEEF);
    checkOutput("raw_disp_byp_done", {31'd0, dispVld[1]}, 32'd0);

    // Set/clear collision on x7
    applyStimulus(1, 0, 0, 7, 1, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 7, 1, 1, 7, 32'h0000_0777, 0);
    #1 checkBoth("coll_rdy", {31'd0, issueRdy[0]}, {31'd0, issueRdy[1]}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkBoth("coll_busy7", {31'd0, busyOut[0][7]}, {31'd0, busyOut[1][7]}, 32'd1);
    step();
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBoth("coll_flushed", busyOut[0], busyOut[1], 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkBoth("coll_x7", rs1Out[0], rs1Out[1], 32'h0000_0777);

    // x0 handling
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    step();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
    #1 checkBoth("x0_rdy", {31'd0, issueRdy[0]}, {31'd0, issueRdy[1]}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkBoth("x0_disp", {31'd0, dispVld[0]}, {31'd0, dispVld[1]}, 32'd1);
    checkBoth("x0_rs1", rs1Out[0], rs1Out[1], 32'd0);
    checkBoth("x0_busy", busyOut[0], busyOut[1], 32'd0);

    // Flush
    applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 9, 1, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkBoth("flush_pre_busy", busyOut[0], busyOut[1], 32'h0000_0208);
    applyStimulus(1, 0, 0, 4, 1, 0, 0, 0, 1);
    #1 checkBoth("flush_rdy", {31'd0, issueRdy[0]}, {31'd0, issueRdy[1]}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkBoth("flush_busy", busyOut[0], busyOut[1], 32'd0);
    checkBoth("flush_disp", {31'd0, dispVld[0]}, {31'd0, dispVld[1]}, 32'd0);

    // Async reset during back-to-back fires
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 5, 7, 5'(10 + i), 1, 0, 0, 0, 0);
      step();
    end
    #2 reset = 1'b1;
    #1 checkBoth("arst_disp", {31'd0, dispVld[0]}, {31'd0, dispVld[1]}, 32'd0);
    checkBoth("arst_busy", busyOut[0], busyOut[1], 32'd0);
    checkBoth("arst_rs1", rs1Out[0], rs1Out[1], 32'd0);
    step();
    step();
    #2 reset = 1'b0;
    applyStimulus(1, 5, 7, 1, 1, 0, 0, 0, 0);
    #1 checkBoth("arst_after_rdy", {31'd0, issueRdy[0]}, {31'd0, issueRdy[1]}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkBoth("arst_after_disp", {31'd0, dispVld[0]}, {31'd0, dispVld[1]}, 32'd1);
    checkBoth("arst_after_x5", rs1Out[0], rs1Out[1], 32'd0);
    checkBoth("arst_after_x7", rs2Out[0], rs2Out[1], 32'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
